// File: rtl/s2p.sv
// s2p: serial-to-parallel receiver.
// Reassembles MSB-first frames of 1-16 bits into a left-aligned 16-bit word
// and flags each completed word with a one-cycle done pulse.
// Optional feature: define S2P_PARITY_EN to append a parity bit to every
// frame; ODD_PARITY selects the parity sense (0 = even, 1 = odd).
module s2p #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    input  logic [3:0]  len,
    input  logic        enable,
    output logic [15:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        parity_err
);

`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  flen_q, flen_d;
    logic [15:0] data_out_q, data_out_d;
    logic        done_q, done_d;
    logic        last_bit;
    logic [3:0]  bit_idx;

`ifdef S2P_PARITY_EN
    logic        par_q, par_d;
    logic        parity_err_q, parity_err_d;
`else
    logic        unused_cfg;
    assign unused_cfg = ODD_PARITY;
`endif

    // Bit position written by the next sample in SHIFT (MSB first).
    assign bit_idx = 4'd15 - cnt_q[3:0];

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            flen_q       <= 5'd16;
            data_out_q   <= '0;
            done_q       <= 1'b0;
`ifdef S2P_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            flen_q       <= flen_d;
            data_out_q   <= data_out_d;
            done_q       <= done_d;
`ifdef S2P_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: sample one bit per enabled edge, complete the frame
    // when the latched length is reached (or after the parity bit).
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        flen_d     = flen_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        last_bit   = 1'b0;
`ifdef S2P_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    flen_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
                    shreg_d  = {data_in, 15'd0};
                    cnt_d    = 5'd1;
                    state_d  = SHIFT;
                    last_bit = (flen_d == 5'd1);
`ifdef S2P_PARITY_EN
                    par_d    = data_in;
`endif
                end
            end
            SHIFT: begin
                if (enable) begin
                    shreg_d[bit_idx] = data_in;
                    cnt_d            = cnt_q + 5'd1;
                    last_bit         = (cnt_d == flen_q);
`ifdef S2P_PARITY_EN
                    par_d            = par_q ^ data_in;
`endif
                end
            end
`ifdef S2P_PARITY_EN
            PAR: begin
                if (enable) begin
                    parity_err_d = ((par_q ^ data_in) != ODD_PARITY);
                    data_out_d   = shreg_q;
                    done_d       = 1'b1;
                    cnt_d        = 5'd0;
                    state_d      = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (last_bit) begin
`ifdef S2P_PARITY_EN
            state_d    = PAR;
`else
            data_out_d = shreg_d;
            done_d     = 1'b1;
            cnt_d      = 5'd0;
            state_d    = IDLE;
`endif
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
`ifdef S2P_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: self-checking bench for s2p with directed and randomized frames
// compared against a frame-level reference model.
module tb_s2p;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_in;
    logic [3:0]  len;
    logic        enable;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic        parity_err;

    int          n_checks = 0;
    int          n_bad    = 0;
    logic [15:0] exp_data = '0;
    logic        exp_perr = 1'b0;

    s2p #(.ODD_PARITY(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .len       (len),
        .enable    (enable),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle inside or between frames: no sample, outputs must hold.
    task automatic pause_cycle(input bit in_frame);
        enable  = 1'b0;
        data_in = 1'($urandom);
        len     = 4'($urandom);
        tick();
        check("pause_done", done, 0);
        check("pause_busy", busy, in_frame);
        check("pause_data", data_out, exp_data);
    endtask

    // Send one frame. Model: the result is the top flen bits of word,
    // lower bits zero; parity error when XOR(data, parity bit) is 1.
    task automatic send_frame(input logic [3:0] lenv, input logic [15:0] word,
                              input int gap, input int pause_at, input logic par_bit);
        int          flen;
        int          nbits;
        logic [15:0] mask;
        flen  = (lenv == 4'd0) ? 16 : int'(lenv);
        nbits = flen;
`ifdef S2P_PARITY_EN
        nbits = flen + 1;
`endif
        mask = 16'hFFFF << (16 - flen);
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at)
                for (int k = 0; k < 3; k++) pause_cycle(1'b1);
            while (int'($urandom_range(99)) < gap) pause_cycle(i > 0);
            enable  = 1'b1;
            data_in = (i < flen) ? word[15 - i] : par_bit;
            len     = (i == 0) ? lenv : 4'($urandom);
            tick();
            if (i < nbits - 1) begin
                check("mid_done", done, 0);
                check("mid_busy", busy, 1);
                check("mid_data", data_out, exp_data);
            end else begin
                exp_data = word & mask;
`ifdef S2P_PARITY_EN
                exp_perr = (^(word & mask)) ^ par_bit;
`endif
                check("end_done", done, 1);
                check("end_data", data_out, exp_data);
                check("end_busy", busy, 0);
                check("end_perr", parity_err, exp_perr);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        data_in = 1'b0;
        len     = 4'd0;
        #12;
        check("rst_data", data_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", parity_err, 0);
        tick();
        reset = 1'b1;
        tick();

        // Directed frames.
        send_frame(4'd8, 16'hB200, 0, -1, 1'b0);
        pause_cycle(1'b0);
        send_frame(4'd0, 16'hA5C3, 0, -1, 1'b0);
        send_frame(4'd1, 16'h8000, 0, -1, 1'b1);
        pause_cycle(1'b0);
        send_frame(4'd4, 16'hD000, 0, 2, 1'b1);
        send_frame(4'd4, 16'h7000, 0, -1, 1'b1);
        send_frame(4'd8, 16'h5A00, 0, -1, 1'b0);
`ifdef S2P_PARITY_EN
        send_frame(4'd4, 16'hB000, 0, -1, 1'b1);
        send_frame(4'd4, 16'hB000, 0, -1, 1'b0);
`endif

        // Reset in the middle of a frame.
        enable = 1'b1;
        len    = 4'd8;
        for (int i = 0; i < 5; i++) begin
            data_in = 1'b1;
            tick();
        end
        enable = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        exp_data = '0;
        exp_perr = 1'b0;
        check("mrst_data", data_out, 0);
        check("mrst_done", done, 0);
        check("mrst_busy", busy, 0);
        check("mrst_perr", parity_err, 0);
        tick();
        reset = 1'b1;
        tick();
        send_frame(4'd8, 16'hFF00, 0, -1, 1'b0);

        // Randomized frames, with and without gaps.
        for (int f = 0; f < 300; f++)
            send_frame(4'($urandom), 16'($urandom), (f < 100) ? 0 : 30, -1, 1'($urandom));
        pause_cycle(1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/s2p.md
# s2p

Serial-to-parallel receiver that reassembles MSB-first bit streams of 1–16 bits into a left-aligned 16-bit word. It sits at the receiving end of the single-wire serial link driven by the team's parallel-to-serial transmitter. It samples one bit per enabled clock and presents the completed word with a one-cycle `done` pulse.

## Interface
- `ODD_PARITY`, default 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- `clk`  in  1  system clock; all sampling on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial bit, MSB first.
- `len`  in  4  frame length in bits; 1–15 literal, 0 = 16 bits.
- `enable`  in  1  while high, one bit is sampled per clock.
- `data_out`  out  16  last completed word, left-aligned; unused low bits are 0.
- `done`  out  1  one-cycle pulse: `data_out` was updated.
- `busy`  out  1  a frame is partially received.
- `parity_err`  out  1  parity result of the last completed frame (see Configuration).

## Operation
- Internal state:
  - `shreg[15:0]`
  - bit counter `cnt[4:0]`
  - latched length `flen[4:0]` (1–16)
  - FSM `IDLE` / `SHIFT` / `PAR`. `PAR` exists only with the macro.
- `IDLE`, on a rising edge with `enable=1`:
  - `flen` ← (`len`==0 ? 16 : `len`).
  - `shreg[15]` ← `data_in`; all other `shreg` bits ← 0.
  - `cnt` ← 1.
  - If `flen`==1, the frame completes on this edge. Otherwise go to `SHIFT`.
- `SHIFT`, on a rising edge with `enable=1`:
  - `shreg[15-cnt]` ← `data_in`; `cnt` ← `cnt`+1.
  - When `cnt`+1 == `flen`, the frame completes.
- `enable=0` in `SHIFT` or `PAR`: the frame pauses. `cnt`, `shreg` and state hold, and no sample is taken.
- Frame completion, without parity (registered on the completing edge):
  - `data_out` ← final `shreg` value, including the bit sampled this edge.
  - `done` ← 1.
  - `cnt` ← 0; state ← `IDLE`.
- `len` is ignored after the first bit of a frame. Changing it mid-frame has no effect.
- Back-to-back frames: if `enable` stays high after completion, the next edge starts a new frame from `IDLE`. There are no gap cycles.
- `busy` = (state != `IDLE`).
- Bits below position 16-`flen` in `data_out` are always 0.

## Timing
- Reset values: `data_out`=0, `done`=0, `busy`=0, `parity_err`=0; `cnt`=0; state `IDLE`.
- Reset assertion mid-frame aborts the frame immediately. No `done` is produced and the partial data is discarded.
- Latency: `done` and the new `data_out` are visible in the cycle after the edge that sampled the last bit (the last parity bit when parity is enabled).
- `done` is high for exactly one cycle per frame. It is never asserted without a completed frame.
- `data_out` holds its value between `done` pulses, including while the next frame is being shifted.
- Frame duration with continuous `enable`: `flen` cycles, or `flen`+1 with parity.

## Configuration
- Macro `S2P_PARITY_EN`.
- Defined:
  - After the last data bit the FSM enters `PAR`. The next enabled edge samples the parity bit and completes the frame.
  - `parity_err` ← 1 if XOR(data bits, parity bit) != `ODD_PARITY`.
  - `parity_err` is updated together with `data_out` and `done`, then held until the next completion.
  - `data_out` is updated even on a parity error.
- Undefined:
  - No `PAR` state; frames are `flen` bits.
  - `parity_err` is tied to 0.

## Test plan
- Basic frame: `len`=8, `enable` high for 8 cycles, serial 1,0,1,1,0,0,1,0 → `data_out`=16'hB200, `done` high for 1 cycle on the cycle after the 8th edge, `busy` high during the frame.
- Full width and single bit:
  - `len`=0 with stream 16'hA5C3 → `data_out`=16'hA5C3 after 16 edges.
  - Then `len`=1 with bit 1 → `data_out`=16'h8000 and `done` on the next cycle.
- Pause and back-to-back:
  - `len`=4, bits 1,1 then `enable` low for 3 cycles, then bits 0,1 → `data_out`=16'hD000; `busy` stays 1 during the pause.
  - Immediately after, `len`=4 with 0,1,1,1 and no gap → second `done` exactly 4 cycles after the first, `data_out`=16'h7000.
- Reset mid-frame: `len`=8, assert `reset` low after 5 bits → `data_out`=0, `done`=0, `busy`=0. After release, a full frame 16'hFF00 (`len`=8, all ones) completes correctly.
- `len` change mid-frame: start with `len`=8, switch `len` to 3 after 2 bits → frame still completes after 8 bits.
- With `S2P_PARITY_EN`, `ODD_PARITY`=0:
  - `len`=4, data 1,0,1,1 plus parity 1 → `data_out`=16'hB000, `parity_err`=0.
  - The same frame with parity 0 → `parity_err`=1, and `done` is still pulsed.
